// File: rtl/dmg_timer_pkg.sv
// Shared definitions for the DMG timer: register map, TAC tap selection and FSM states.
// Used by dmg_timer and dmg_timer_edge; see dmg_timer.sv for the DMG_TIMER_FREEZE_EN option.
package dmg_timer_pkg;

  localparam logic [1:0] REG_DIV  = 2'd0;
  localparam logic [1:0] REG_TIMA = 2'd1;
  localparam logic [1:0] REG_TMA  = 2'd2;
  localparam logic [1:0] REG_TAC  = 2'd3;

  localparam logic [1:0] TAC_SEL_4K   = 2'b00;
  localparam logic [1:0] TAC_SEL_262K = 2'b01;
  localparam logic [1:0] TAC_SEL_65K  = 2'b10;
  localparam logic [1:0] TAC_SEL_16K  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    RELOAD = 2'd2
  } state_t;

  // Divider bit that clocks TIMA for a given TAC[1:0] frequency select.
  function automatic int unsigned div_tap(input logic [1:0] tac_sel);
    int unsigned tap;
    case (tac_sel)
      TAC_SEL_4K:   tap = 32'd9;
      TAC_SEL_262K: tap = 32'd3;
      TAC_SEL_65K:  tap = 32'd5;
      TAC_SEL_16K:  tap = 32'd7;
      default:      tap = 32'd9;
    endcase
    return tap;
  endfunction

endpackage

// File: rtl/dmg_timer_edge.sv
// Gated tick mux with a falling-edge detector; also usable with all four taps tied
// to a single divider bit (e.g. the APU frame sequencer off div[12]).
module dmg_timer_edge
  import dmg_timer_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic [3:0] src,
  input  logic [1:0] sel,
  input  logic       en,
  input  logic       hold,
  output logic       fall
);

  logic tick_s;
  logic tick_prev_r;

  // Selected divider bit gated by the enable; disabling while high is a real edge.
  always_comb begin
    tick_s = en & src[sel];
  end

  // History of the gated tick; frozen while hold is asserted so release adds no edge.
  always_ff @(posedge clk) begin
    if (res) begin
      tick_prev_r <= 1'b0;
    end else if (hold) begin
      tick_prev_r <= tick_prev_r;
    end else begin
      tick_prev_r <= tick_s;
    end
  end

  // Falling edge of the gated tick, suppressed during hold.
  always_comb begin
    fall = tick_prev_r & ~tick_s & ~hold;
  end

endmodule

// File: rtl/dmg_timer.sv
// DMG DIV/TIMA/TMA/TAC timer with delayed TMA reload and one-cycle IRQ pulse.
// Optional DMG_TIMER_FREEZE_EN adds a freeze input that halts div, tima and edge history.
module dmg_timer
  import dmg_timer_pkg::*;
#(
  parameter int DIV_WIDTH    = 16,
  parameter int RELOAD_DELAY = 4
) (
  input  logic       clk,
  input  logic       res,
  input  logic [1:0] addr,
  input  logic       sel,
  input  logic       wr,
  input  logic [7:0] din,
`ifdef DMG_TIMER_FREEZE_EN
  input  logic       freeze,
`endif
  output logic [7:0] dout,
  output logic       irq
);

  localparam int CNT_W = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELOAD_DELAY - 1);

  logic [DIV_WIDTH-1:0] div_r;
  logic [7:0]           tima_r;
  logic [7:0]           tma_r;
  logic [2:0]           tac_r;
  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 irq_r;

  logic [7:0]       tima_s;
  logic [7:0]       tma_next_s;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_s;
  logic             wr_div_s;
  logic             wr_tima_s;
  logic             wr_tma_s;
  logic             wr_tac_s;
  logic             freeze_s;
  logic             fall_s;
  logic [3:0]       src_s;

  // Register write decode.
  always_comb begin
    wr_div_s  = sel & wr & (addr == REG_DIV);
    wr_tima_s = sel & wr & (addr == REG_TIMA);
    wr_tma_s  = sel & wr & (addr == REG_TMA);
    wr_tac_s  = sel & wr & (addr == REG_TAC);
    tma_next_s = wr_tma_s ? din : tma_r;
`ifdef DMG_TIMER_FREEZE_EN
    freeze_s = freeze;
`else
    freeze_s = 1'b0;
`endif
  end

  for (genvar i = 0; i < 4; i++) begin : g_tap
    assign src_s[i] = div_r[div_tap(2'(i))];
  end

  dmg_timer_edge u_edge (
    .clk  (clk),
    .res  (res),
    .src  (src_s),
    .sel  (tac_r[1:0]),
    .en   (tac_r[2]),
    .hold (freeze_s),
    .fall (fall_s)
  );

  // Free-running divider; any DIV write clears it, even while frozen.
  always_ff @(posedge clk) begin
    if (res) begin
      div_r <= '0;
    end else if (wr_div_s) begin
      div_r <= '0;
    end else if (freeze_s) begin
      div_r <= div_r;
    end else begin
      div_r <= div_r + DIV_WIDTH'(1);
    end
  end

  // TMA and TAC configuration registers.
  always_ff @(posedge clk) begin
    if (res) begin
      tma_r <= 8'h00;
      tac_r <= 3'b000;
    end else begin
      tma_r <= tma_next_s;
      tac_r <= wr_tac_s ? din[2:0] : tac_r;
    end
  end

  // Overflow/reload sequencer and TIMA next value; CPU writes outrank tick edges.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    tima_s  = tima_r;
    case (state_r)
      IDLE: begin
        if (wr_tima_s) begin
          tima_s = din;
        end else if (fall_s) begin
          if (tima_r == 8'hFF) begin
            tima_s  = 8'h00;
            state_s = DELAY;
            cnt_s   = '0;
          end else begin
            tima_s = tima_r + 8'd1;
          end
        end else begin
          tima_s = tima_r;
        end
      end
      DELAY: begin
        if (wr_tima_s) begin
          tima_s  = din;
          state_s = IDLE;
          cnt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          tima_s  = tma_next_s;
          state_s = RELOAD;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      RELOAD: begin
        // TIMA tracks TMA (including a same-cycle TMA write); TIMA writes are dropped.
        tima_s  = tma_next_s;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Sequencer state, TIMA and the registered IRQ pulse.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      tima_r  <= 8'h00;
      irq_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      tima_r  <= tima_s;
      irq_r   <= (state_s == RELOAD);
    end
  end

  // Read mux.
  always_comb begin
    case (addr)
      REG_DIV:  dout = div_r[DIV_WIDTH-1 -: 8];
      REG_TIMA: dout = tima_r;
      REG_TMA:  dout = tma_r;
      REG_TAC:  dout = {5'b11111, tac_r};
      default:  dout = 8'h00;
    endcase
  end

  assign irq = irq_r;

endmodule

// File: tb/tb_dmg_timer.sv
// Directed bench for dmg_timer: expected values queued on stimulus, compared on readout.
// Define DMG_TIMER_FREEZE_EN to also exercise the freeze input.
module tb_dmg_timer;
  import dmg_timer_pkg::*;

  logic       clk = 1'b0;
  logic       res;
  logic [1:0] addr;
  logic       sel;
  logic       wr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;
`ifdef DMG_TIMER_FREEZE_EN
  logic       freeze;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  dmg_timer dut (
    .clk    (clk),
    .res    (res),
    .addr   (addr),
    .sel    (sel),
    .wr     (wr),
    .din    (din),
`ifdef DMG_TIMER_FREEZE_EN
    .freeze (freeze),
`endif
    .dout   (dout),
    .irq    (irq)
  );

  always #10 clk = ~clk;

  task automatic check_reg(input logic [1:0] a, input logic [7:0] e, input string t);
    logic [7:0] ev;
    string      tg;
    exp_q.push_back(e);
    tag_q.push_back(t);
    addr = a;
    #1;
    ev = exp_q.pop_front();
    tg = tag_q.pop_front();
    checks++;
    assert (dout === ev) else begin
      errors++;
      $error("FAIL %s: dout=%02h expected=%02h", tg, dout, ev);
    end
  endtask

  task automatic check_irq(input logic e, input string t);
    logic [7:0] ev;
    string      tg;
    exp_q.push_back({7'd0, e});
    tag_q.push_back(t);
    #1;
    ev = exp_q.pop_front();
    tg = tag_q.pop_front();
    checks++;
    assert ({7'd0, irq} === ev) else begin
      errors++;
      $error("FAIL %s: irq=%0b expected=%0b", tg, irq, ev[0]);
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    sel  = 1'b1;
    wr   = 1'b1;
    addr = a;
    din  = d;
    @(posedge clk);
    #1;
    sel = 1'b0;
    wr  = 1'b0;
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    res = 1'b1; sel = 1'b0; wr = 1'b0; addr = 2'd0; din = 8'h00;
`ifdef DMG_TIMER_FREEZE_EN
    freeze = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    check_reg(REG_DIV,  8'h00, "rst_div");
    check_reg(REG_TIMA, 8'h00, "rst_tima");
    check_reg(REG_TMA,  8'h00, "rst_tma");
    check_reg(REG_TAC,  8'hF8, "rst_tac");
    check_irq(1'b0, "rst_irq");
    cycles(255);
    check_reg(REG_DIV, 8'h00, "div_255");
    cycles(1);
    check_reg(REG_DIV, 8'h01, "div_256");

    // Overflow and reload; div is known from here on (comments give div at each point).
    write_reg(REG_DIV, 8'h5A);           // div=0
    write_reg(REG_TMA, 8'hF0);           // div=1
    write_reg(REG_TIMA, 8'hFE);          // div=2
    write_reg(REG_TAC, 8'h05);           // div=3
    check_reg(REG_TAC, 8'hFD, "tac_rd");
    cycles(13);                          // div=16
    check_reg(REG_TIMA, 8'hFE, "tima_fe");
    cycles(1);
    check_reg(REG_TIMA, 8'hFF, "tima_ff");
    cycles(16);                          // div=33: overflow, DELAY
    check_reg(REG_TIMA, 8'h00, "ovf_zero");
    check_irq(1'b0, "ovf_noirq");
    cycles(3);                           // div=36: last DELAY cycle
    check_reg(REG_TIMA, 8'h00, "delay_end");
    check_irq(1'b0, "delay_noirq");
    cycles(1);                           // div=37: RELOAD
    check_reg(REG_TIMA, 8'hF0, "reload_tima");
    check_irq(1'b1, "reload_irq");
    cycles(1);
    check_reg(REG_TIMA, 8'hF0, "post_tima");
    check_irq(1'b0, "post_irq");

    // TIMA write during DELAY cancels reload.
    write_reg(REG_TIMA, 8'hFF);          // div=39
    cycles(10);                          // div=49
    check_reg(REG_TIMA, 8'h00, "ovf2_zero");
    cycles(1);
    write_reg(REG_TIMA, 8'h42);          // div=51
    check_reg(REG_TIMA, 8'h42, "cancel_tima");
    check_irq(1'b0, "cancel_irq0");
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      check_irq(1'b0, "cancel_irq");
    end
    check_reg(REG_TIMA, 8'h42, "cancel_hold");

    // DIV write with the tap high gives one spurious increment.
    cycles(2);                           // div=57, bit3=1
    write_reg(REG_DIV, 8'h00);           // div=0
    check_reg(REG_DIV, 8'h00, "divwr_div");
    check_reg(REG_TIMA, 8'h42, "divwr_pre");
    cycles(1);
    check_reg(REG_TIMA, 8'h43, "spur_inc");
    cycles(14);                          // div=15
    check_reg(REG_TIMA, 8'h43, "spur_once");
    cycles(2);                           // div=17
    check_reg(REG_TIMA, 8'h44, "nat_inc");
    write_reg(REG_DIV, 8'h00);           // bit3=0 before clear
    check_reg(REG_TIMA, 8'h44, "divwr_lo0");
    cycles(5);
    check_reg(REG_TIMA, 8'h44, "divwr_lo5");

    // TMA write on the RELOAD cycle.
    write_reg(REG_TIMA, 8'hFF);          // div=6
    cycles(15);                          // div=21: RELOAD
    check_irq(1'b1, "tmawr_irq");
    check_reg(REG_TIMA, 8'hF0, "tmawr_pre");
    write_reg(REG_TMA, 8'h77);
    check_reg(REG_TIMA, 8'h77, "tmawr_tima");
    check_reg(REG_TMA, 8'h77, "tmawr_tma");
    check_irq(1'b0, "tmawr_irq0");

    // TIMA write on the RELOAD cycle is ignored.
    write_reg(REG_TIMA, 8'hFF);          // div=23
    cycles(14);                          // div=37: RELOAD
    check_irq(1'b1, "timawr_irq");
    write_reg(REG_TIMA, 8'h11);
    check_reg(REG_TIMA, 8'h77, "timawr_ign");

    // Reset during DELAY aborts the reload.
    write_reg(REG_TIMA, 8'hFF);          // div=39
    cycles(10);                          // div=49: DELAY
    check_reg(REG_TIMA, 8'h00, "rstd_delay");
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_irq(1'b0, "rstd_irq");
      cycles(1);
    end
    check_reg(REG_TIMA, 8'h00, "rstd_tima");
    check_reg(REG_TMA, 8'h00, "rstd_tma");
    check_reg(REG_TAC, 8'hF8, "rstd_tac");

`ifdef DMG_TIMER_FREEZE_EN
    write_reg(REG_DIV, 8'h00);           // div=0
    write_reg(REG_TAC, 8'h05);           // div=1
    write_reg(REG_TIMA, 8'h10);          // div=2
    cycles(263);                         // div=0x109, tap high
    check_reg(REG_DIV, 8'h01, "frz_div0");
    check_reg(REG_TIMA, 8'h20, "frz_tima0");
    freeze = 1'b1;
    cycles(100);
    check_reg(REG_DIV, 8'h01, "frz_div");
    check_reg(REG_TIMA, 8'h20, "frz_tima");
    freeze = 1'b0;
    cycles(7);                           // div=0x110
    check_reg(REG_TIMA, 8'h20, "frz_noextra");
    cycles(1);
    check_reg(REG_TIMA, 8'h21, "frz_resume");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
